// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for mem_copy_master: register map, control/status bit
// positions, bus strobe encodings and FSM state encoding.
package mem_copy_master_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_SRC    = 8'h02;
  localparam logic [7:0] ADDR_DST    = 8'h03;
  localparam logic [7:0] ADDR_LEN    = 8'h04;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERROR_BIT  = 2;

  localparam logic [3:0] WSTRB_READ  = 4'h0;
  localparam logic [3:0] WSTRB_WRITE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_READ_GAP  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_GAP = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_master.sv
// Register-programmed word copy engine: reads LEN words from SRC and writes
// them to DST over a valid/ready bus master port, with abort and timeout.
module mem_copy_master
  import mem_copy_master_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int LEN_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state_reg;
  logic [29:0]       src_reg;
  logic [29:0]       dst_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;
  logic              abort_reg;
  logic [29:0]       wsrc_reg;
  logic [29:0]       wdst_reg;
  logic [LEN_W-1:0]  wcnt_reg;
  logic [31:0]       data_reg;
  logic [TMO_W-1:0]  tmo_reg;

  logic reg_wr;
  logic start_wr;
  logic abort_wr;
  logic tmo_expire;

  assign reg_wr     = cs && we;
  assign start_wr   = reg_wr && (address == ADDR_CTRL) && write_data[CTRL_START_BIT];
  assign abort_wr   = reg_wr && (address == ADDR_CTRL) && write_data[CTRL_ABORT_BIT];
  assign tmo_expire = (tmo_reg == TMO_W'(TIMEOUT - 1));

  assign ready = cs;

  always_comb begin
    read_data = '0;
    if (cs) begin
      case (address)
        ADDR_STATUS: begin
          read_data[STAT_BUSY_BIT]  = busy_reg;
          read_data[STAT_DONE_BIT]  = done_reg;
          read_data[STAT_ERROR_BIT] = error_reg;
        end
        ADDR_SRC: read_data = {src_reg, 2'b00};
        ADDR_DST: read_data = {dst_reg, 2'b00};
        ADDR_LEN: read_data = 32'(len_reg);
        default:  read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      abort_reg <= 1'b0;
      wsrc_reg  <= '0;
      wdst_reg  <= '0;
      wcnt_reg  <= '0;
      data_reg  <= '0;
      tmo_reg   <= '0;
      mem_valid <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (reg_wr && !busy_reg) begin
        case (address)
          ADDR_SRC: src_reg <= write_data[31:2];
          ADDR_DST: dst_reg <= write_data[31:2];
          ADDR_LEN: len_reg <= write_data[LEN_W-1:0];
          default:  ;
        endcase
      end
      // Only a running copy can be aborted; a START in the same cycle
      // from idle sees busy low here, so START wins.
      if (abort_wr && busy_reg) begin
        abort_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start_wr) begin
            error_reg <= 1'b0;
            if (len_reg != '0) begin
              done_reg  <= 1'b0;
              busy_reg  <= 1'b1;
              wsrc_reg  <= src_reg;
              wdst_reg  <= dst_reg;
              wcnt_reg  <= len_reg;
              mem_valid <= 1'b1;
              mem_wstrb <= WSTRB_READ;
              mem_addr  <= {src_reg, 2'b00};
              tmo_reg   <= '0;
              state_reg <= ST_READ;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (mem_ready) begin
            data_reg  <= mem_rdata;
            mem_valid <= 1'b0;
            state_reg <= ST_READ_GAP;
          end else if (tmo_expire) begin
            mem_valid <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b1;
            abort_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end

        ST_READ_GAP: begin
          mem_valid <= 1'b1;
          mem_wstrb <= WSTRB_WRITE;
          mem_addr  <= {wdst_reg, 2'b00};
          mem_wdata <= data_reg;
          tmo_reg   <= '0;
          state_reg <= ST_WRITE;
        end

        ST_WRITE: begin
          if (mem_ready) begin
            wsrc_reg  <= wsrc_reg + 30'd1;
            wdst_reg  <= wdst_reg + 30'd1;
            wcnt_reg  <= wcnt_reg - LEN_W'(1);
            mem_valid <= 1'b0;
            state_reg <= ST_WRITE_GAP;
          end else if (tmo_expire) begin
            mem_valid <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b1;
            abort_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end

        ST_WRITE_GAP: begin
          if ((wcnt_reg == '0) || abort_reg) begin
            busy_reg  <= 1'b0;
            done_reg  <= !abort_reg;
            abort_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            mem_valid <= 1'b1;
            mem_wstrb <= WSTRB_READ;
            mem_addr  <= {wsrc_reg, 2'b00};
            tmo_reg   <= '0;
            state_reg <= ST_READ;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: a memory responder and monitor compare
// every bus transfer against copies predicted from the register programming.
module tb_mem_copy_master;

  localparam int TMO = 16;
  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h01, A_SRC = 8'h02,
                         A_DST = 8'h03, A_LEN = 8'h04;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        mem_valid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_copy_master #(.TIMEOUT(TMO), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_valid(mem_valid), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  int          valid_cycles = 0;
  bit          resp_en = 1'b1;
  bit          noise = 1'b0;
  int          lat_max = 1;
  int          lat = 1;
  int          wait_cnt = 0;
  bit          ack_pend = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Responder and monitor, evaluated once per cycle on the falling edge:
  // mem_ready set here is what the DUT samples on the next rising edge.
  task automatic monitor_step();
    txn_t e;
    if (mem_valid) valid_cycles++;
    if (ack_pend) chk("valid_drop_after_ack", {31'd0, mem_valid}, 32'd0);
    ack_pend = 1'b0;
    if (!mem_valid) begin
      wait_cnt  = 0;
      lat       = $urandom_range(lat_max, 1);
      mem_ready = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    end else if (!resp_en || !reset_n) begin
      mem_ready = 1'b0;
    end else if (wait_cnt >= lat) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'b0;
      wait_cnt++;
    end
    if (mem_ready && mem_valid && reset_n) begin
      ack_pend = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn: got wstrb=%h addr=0x%08h required no transfer",
                 mem_wstrb, mem_addr);
      end else begin
        e = exp_q.pop_front();
        chk("txn_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        chk("txn_addr", mem_addr, e.addr);
        if (e.wstrb == 4'hF) chk("txn_wdata", mem_wdata, e.data);
      end
      if (mem_wstrb == 4'h0) begin
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        rd_seen++;
      end else begin
        mem[mem_addr] = mem_wdata;
        wr_seen++;
      end
      $display("txn wstrb=%h addr=0x%08h wdata=0x%08h", mem_wstrb, mem_addr, mem_wdata);
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    d = read_data;
    cs = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    reg_read(a, v);
    chk(name, v, exp);
  endtask

  task automatic wait_idle(output int cycles);
    logic [31:0] v;
    cycles = 0;
    forever begin
      reg_read(A_STATUS, v);
      if (!v[0]) break;
      cycles++;
      if (cycles > 3000) begin
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles", cycles);
        break;
      end
    end
  endtask

  // Reference: a copy of len words moves mem[src+4i] to dst+4i, each as a
  // read then a write, addresses wrapping at 2^32.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] data_q[$];
    logic [31:0] a;
    logic [31:0] d;
    int cyc;
    reg_write(A_SRC, src);
    reg_write(A_DST, dst);
    reg_write(A_LEN, 32'(len));
    for (int i = 0; i < len; i++) begin
      a = src + 32'(4 * i);
      d = mem.exists(a) ? mem[a] : $urandom;
      mem[a] = d;
      data_q.push_back(d);
      exp_q.push_back('{4'h0, a, 32'h0});
      exp_q.push_back('{4'hF, dst + 32'(4 * i), d});
    end
    reg_write(A_CTRL, 32'h1);
    wait_idle(cyc);
    check_reg("copy_status", A_STATUS, 32'h2);
    chk("copy_all_seen", 32'(exp_q.size()), 32'd0);
    chk("copy_busy_cycles", 32'(cyc >= 4 * len), 32'd1);
    for (int i = 0; i < len; i++)
      chk("copy_dst_mem", mem[dst + 32'(4 * i)], data_q[i]);
    $display("copy src=0x%08h dst=0x%08h len=%0d busy_cycles=%0d", src, dst, len, cyc);
  endtask

  task automatic run_tests();
    logic [31:0] v;
    int cyc;
    int wr0;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1;
    check_reg("rst_status", A_STATUS, 32'h0);
    check_reg("rst_src", A_SRC, 32'h0);
    check_reg("rst_len", A_LEN, 32'h0);
    @(negedge clk);
    cs = 1'b1; address = A_SRC; #1;
    chk("ready_cs_high", {31'd0, ready}, 32'd1);
    cs = 1'b0; #1;
    chk("ready_cs_low", {31'd0, ready}, 32'd0);
    chk("rdata_cs_low", read_data, 32'h0);

    reg_write(A_SRC, 32'h1234_5677);
    check_reg("src_low_bits", A_SRC, 32'h1234_5674);
    reg_write(8'h07, 32'hFFFF_FFFF);
    check_reg("unmapped_read", 8'h07, 32'h0);
    check_reg("ctrl_read", A_CTRL, 32'h0);

    mem[32'h4000_0000] = 32'hDEAD_BEEF;
    run_copy(32'h4000_0000, 32'h4000_0100, 1);
    run_copy(32'h4000_0200, 32'h4000_0300, 4);

    noise = 1'b1;
    lat_max = 3;
    for (int t = 0; t < 6; t++)
      run_copy({1'b0, 31'($urandom) & 31'h7FFF_FFF0}, {1'b1, 31'($urandom) & 31'h7FFF_FFF0},
               $urandom_range(6, 1));
    run_copy(32'hFFFF_FFF8, 32'h1000_0000, 4);
    noise = 1'b0;
    lat_max = 1;

    // Abort during the 3rd read: three full pairs, then stop.
    reg_write(A_SRC, 32'h2000_0000);
    reg_write(A_DST, 32'h9000_0000);
    reg_write(A_LEN, 32'd8);
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      mem[32'h2000_0000 + 32'(4 * i)] = v;
      exp_q.push_back('{4'h0, 32'h2000_0000 + 32'(4 * i), 32'h0});
      exp_q.push_back('{4'hF, 32'h9000_0000 + 32'(4 * i), v});
    end
    wr0 = wr_seen;
    reg_write(A_CTRL, 32'h1);
    reg_write(A_SRC, 32'h3333_3330);
    reg_write(A_LEN, 32'd2);
    reg_write(A_CTRL, 32'h1);
    n = 0;
    while (!(rd_seen - (wr0) >= 2 + 0 && mem_valid && mem_wstrb == 4'h0 && wr_seen - wr0 >= 2)
           && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_3rd_read", 32'(n < 500), 32'd1);
    reg_write(A_CTRL, 32'h2);
    wait_idle(cyc);
    repeat (20) @(negedge clk);
    check_reg("abort_status", A_STATUS, 32'h0);
    chk("abort_writes", 32'(wr_seen - wr0), 32'd3);
    chk("abort_all_seen", 32'(exp_q.size()), 32'd0);
    check_reg("busy_src_ignored", A_SRC, 32'h2000_0000);
    check_reg("busy_len_ignored", A_LEN, 32'd8);

    // Responder stalls: request held exactly TMO cycles, then error.
    resp_en = 1'b0;
    reg_write(A_LEN, 32'd2);
    valid_cycles = 0;
    reg_write(A_CTRL, 32'h1);
    wait_idle(cyc);
    repeat (5) @(negedge clk);
    chk("timeout_valid_cycles", 32'(valid_cycles), 32'(TMO));
    check_reg("timeout_status", A_STATUS, 32'h4);
    resp_en = 1'b1;

    reg_write(A_LEN, 32'd0);
    valid_cycles = 0;
    reg_write(A_CTRL, 32'h3);
    check_reg("len0_status", A_STATUS, 32'h2);
    repeat (10) @(negedge clk);
    chk("len0_no_valid", 32'(valid_cycles), 32'd0);

    // Reset during a write abandons the copy.
    reg_write(A_SRC, 32'h5000_0000);
    reg_write(A_DST, 32'hA000_0000);
    reg_write(A_LEN, 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{4'h0, 32'h5000_0000 + 32'(4 * i), 32'h0});
      exp_q.push_back('{4'hF, 32'hA000_0000 + 32'(4 * i),
                       mem.exists(32'h5000_0000 + 32'(4 * i)) ? mem[32'h5000_0000 + 32'(4 * i)] : 32'h0});
    end
    reg_write(A_CTRL, 32'h1);
    n = 0;
    while (!(mem_valid && mem_wstrb == 4'hF) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reached_write", 32'(n < 500), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    valid_cycles = 0;
    check_reg("midrst_src", A_SRC, 32'h0);
    check_reg("midrst_dst", A_DST, 32'h0);
    check_reg("midrst_len", A_LEN, 32'h0);
    check_reg("midrst_status", A_STATUS, 32'h0);
    repeat (10) @(negedge clk);
    chk("midrst_no_valid", 32'(valid_cycles), 32'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      run_tests();
      begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached required completion");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
